tropang_rom_loader: RTL

- Sits between the HPS ioctl download stream and the TropicalAngel core ROM/RAM load ports.
- Splits the index-0 ROM stream into three regions:
  - CPU ROM: 16-bit words.
  - Sound ROM: 16-bit words.
  - Graphics: bytes, passed through.
- For the word regions, it pairs even/odd bytes into 16-bit words with one write strobe per word.
- Captures DIP bytes (index 254) into the two DIP switch registers that feed dip_switch_1/2.
- Reports load completion.

---
 rtl/tropang_rom_loader.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tropang_rom_loader.sv
// tropang_rom_loader
// Bridges the HPS ioctl download stream to the TropicalAngel load ports.
// Index-0 bytes are split into CPU ROM words, sound ROM words and graphics
// bytes; index DIP_INDEX bytes land in the two DIP switch registers.
// Word regions pair even/odd bytes; a lone byte is padded with 8'hFF.

module tropang_rom_loader #(
    parameter logic [24:0] CPU_BASE  = 25'h00000,
    parameter logic [24:0] CPU_SIZE  = 25'h08000,
    parameter logic [24:0] SND_BASE  = 25'h08000,
    parameter logic [24:0] SND_SIZE  = 25'h04000,
    parameter logic [24:0] GFX_BASE  = 25'h0C000,
    parameter logic [24:0] GFX_SIZE  = 25'h14000,
    parameter logic [7:0]  DIP_INDEX = 8'd254
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        cpu_wr,
    output logic [13:0] cpu_addr,
    output logic [15:0] cpu_data,
    output logic        snd_wr,
    output logic [12:0] snd_addr,
    output logic [15:0] snd_data,
    output logic        gfx_wr,
    output logic [16:0] gfx_addr,
    output logic [7:0]  gfx_data,
    output logic [7:0]  dip_sw0,
    output logic [7:0]  dip_sw1,
    output logic        rom_loaded
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_HELD = 1'b1} state_t;
    typedef enum logic {RG_CPU = 1'b0, RG_SND = 1'b1} region_t;

    // One word heading for a CPU or sound load port.
    typedef struct packed {
        logic        vld;
        region_t     rg;
        logic [13:0] waddr;
        logic [15:0] data;
    } word_t;

    localparam logic [7:0] PAD_BYTE = 8'hFF;

    // Address decode
    logic [24:0] cpu_off;
    logic [24:0] snd_off;
    logic [24:0] gfx_off;
    logic        in_cpu;
    logic        in_snd;
    logic        in_gfx;
    logic        rom_byte;
    logic        word_byte;
    logic        gfx_byte;
    logic        byte_odd;
    region_t     cur_rg;
    logic [13:0] cur_waddr;

    // Download edge tracking
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;

    // Word pairing FSM
    state_t      state;
    state_t      state_n;
    logic [7:0]  held_byte;
    logic [7:0]  held_byte_n;
    logic [13:0] held_waddr;
    logic [13:0] held_waddr_n;
    region_t     held_rg;
    region_t     held_rg_n;

    // Word output path: up to two words can be produced in one cycle
    // (flush of the held byte plus a padded odd byte), so the second one
    // waits in a one-deep slot and goes out on the following cycle.
    word_t       req_a;
    word_t       req_b;
    word_t       slot;
    word_t       slot_n;
    word_t       emit;

    // Completion tracking
    logic        got_byte;
    logic        fall_q;

    // Decode the incoming byte: which region it hits and its word position.
    always_comb begin
        // Offsets wrap below the base, so a single unsigned compare
        // against the size rejects addresses on both sides of a region.
        cpu_off   = ioctl_addr - CPU_BASE;
        snd_off   = ioctl_addr - SND_BASE;
        gfx_off   = ioctl_addr - GFX_BASE;
        in_cpu    = (cpu_off < CPU_SIZE);
        in_snd    = !in_cpu && (snd_off < SND_SIZE);
        in_gfx    = !in_cpu && !in_snd && (gfx_off < GFX_SIZE);
        rom_byte  = ioctl_wr && ioctl_download && (ioctl_index == 8'd0);
        word_byte = rom_byte && (in_cpu || in_snd);
        gfx_byte  = rom_byte && in_gfx;
        cur_rg    = in_cpu ? RG_CPU : RG_SND;
        cur_waddr = in_cpu ? cpu_off[14:1] : {1'b0, snd_off[13:1]};
        byte_odd  = in_cpu ? cpu_off[0] : snd_off[0];
        dl_rise   = !dl_q && ioctl_download;
        dl_fall   = dl_q && !ioctl_download;
    end

    // FSM state and held-byte registers.
    always_ff @(posedge clk_sys) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // flops sample the same pre-edge values regardless of block order.
        if (!reset_n) begin
            state      <= ST_EMPTY;
            held_byte  <= 8'd0;
            held_waddr <= 14'd0;
            held_rg    <= RG_CPU;
            dl_q       <= 1'b0;
        end else begin
            state      <= state_n;
            held_byte  <= held_byte_n;
            held_waddr <= held_waddr_n;
            held_rg    <= held_rg_n;
            dl_q       <= ioctl_download;
        end
    end

    // Next-state logic: pair bytes, flush a stranded low byte, pad lone odd bytes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_n      = state;
        held_byte_n  = held_byte;
        held_waddr_n = held_waddr;
        held_rg_n    = held_rg;
        req_a        = '0;
        req_b        = '0;

        case (state)
            ST_EMPTY: begin
                if (word_byte) begin
                    if (!byte_odd) begin
                        held_byte_n  = ioctl_dout;
                        held_waddr_n = cur_waddr;
                        held_rg_n    = cur_rg;
                        state_n      = ST_HELD;
                    end else begin
                        req_a = '{vld: 1'b1, rg: cur_rg, waddr: cur_waddr,
                                  data: {ioctl_dout, PAD_BYTE}};
                    end
                end
            end

            ST_HELD: begin
                if (word_byte) begin
                    if (byte_odd && (cur_waddr == held_waddr) && (cur_rg == held_rg)) begin
                        req_a   = '{vld: 1'b1, rg: held_rg, waddr: held_waddr,
                                    data: {ioctl_dout, held_byte}};
                        state_n = ST_EMPTY;
                    end else begin
                        req_a = '{vld: 1'b1, rg: held_rg, waddr: held_waddr,
                                  data: {PAD_BYTE, held_byte}};
                        if (!byte_odd) begin
                            held_byte_n  = ioctl_dout;
                            held_waddr_n = cur_waddr;
                            held_rg_n    = cur_rg;
                        end else begin
                            req_b   = '{vld: 1'b1, rg: cur_rg, waddr: cur_waddr,
                                        data: {ioctl_dout, PAD_BYTE}};
                            state_n = ST_EMPTY;
                        end
                    end
                end else if (dl_fall) begin
                    req_a   = '{vld: 1'b1, rg: held_rg, waddr: held_waddr,
                                data: {PAD_BYTE, held_byte}};
                    state_n = ST_EMPTY;
                end
            end

            default: state_n = ST_EMPTY;
        endcase
    end

    // Pick the word to send this cycle; anything left over waits in the slot.
    always_comb begin
        emit   = '0;
        slot_n = '0;
        if (slot.vld) begin
            // A full slot implies the FSM went EMPTY last cycle, so at most
            // req_a can be new here and it simply takes the slot's place.
            emit   = slot;
            slot_n = req_a;
        end else if (req_a.vld) begin
            emit   = req_a;
            slot_n = req_b;
        end
    end

    // Registered word strobes towards the CPU and sound ROM ports.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            slot     <= '0;
            cpu_wr   <= 1'b0;
            cpu_addr <= 14'd0;
            cpu_data <= 16'd0;
            snd_wr   <= 1'b0;
            snd_addr <= 13'd0;
            snd_data <= 16'd0;
        end else begin
            slot   <= slot_n;
            cpu_wr <= emit.vld && (emit.rg == RG_CPU);
            snd_wr <= emit.vld && (emit.rg == RG_SND);
            if (emit.vld && (emit.rg == RG_CPU)) begin
                cpu_addr <= emit.waddr;
                cpu_data <= emit.data;
            end
            if (emit.vld && (emit.rg == RG_SND)) begin
                snd_addr <= emit.waddr[12:0];
                snd_data <= emit.data;
            end
        end
    end

    // Graphics bytes pass straight through with one cycle of latency.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            gfx_wr   <= 1'b0;
            gfx_addr <= 17'd0;
            gfx_data <= 8'd0;
        end else begin
            gfx_wr <= gfx_byte;
            if (gfx_byte) begin
                gfx_addr <= gfx_off[16:0];
                gfx_data <= ioctl_dout;
            end
        end
    end

    // DIP bytes are captured whether or not a download is flagged active.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            dip_sw0 <= 8'hFF;
            dip_sw1 <= 8'hFF;
        end else if (ioctl_wr && (ioctl_index == DIP_INDEX)) begin
            if (ioctl_addr == 25'd0) begin
                dip_sw0 <= ioctl_dout;
            end else if (ioctl_addr == 25'd1) begin
                dip_sw1 <= ioctl_dout;
            end
        end
    end

    // Load-complete flag: one cycle behind the fall so any flush lands first.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            got_byte   <= 1'b0;
            fall_q     <= 1'b0;
            rom_loaded <= 1'b0;
        end else begin
            fall_q <= dl_fall && (ioctl_index == 8'd0) && got_byte;
            if (dl_rise && (ioctl_index == 8'd0)) begin
                got_byte   <= rom_byte;
                rom_loaded <= 1'b0;
            end else begin
                if (rom_byte) begin
                    got_byte <= 1'b1;
                end
                if (fall_q) begin
                    rom_loaded <= 1'b1;
                end
            end
        end
    end

endmodule
